// File: rtl/mbist_pkg.sv
// Shared types and March C- tables for the memory BIST controller.
// Element tables are bit vectors indexed by element number M0..M5.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ELEM = 3'd5;

  // Bit e of each vector describes element Me; bits 6/7 are unused padding.
  localparam logic [7:0] ELEM_DOWN  = 8'b0001_1000;  // M3, M4 walk N-1..0
  localparam logic [7:0] ELEM_HAS_R = 8'b0011_1110;  // M1..M5 start with a read
  localparam logic [7:0] ELEM_HAS_W = 8'b0001_1111;  // M0..M4 end with a write
  localparam logic [7:0] ELEM_RPOL  = 8'b0001_0100;  // read expects "1" data
  localparam logic [7:0] ELEM_WPOL  = 8'b0000_1010;  // write stores "1" data

  // Bit i of background b: 0 for b=0, else set when bit (b-1) of i is clear.
  function automatic logic bg_bit(input logic [1:0] b, input int i);
    bg_bit = (b != 2'd0) && (((i >> (int'(b) - 1)) & 1) == 0);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// March sequencer: walks op phase, address, element and background in that
// order, one op per adv pulse; last flags the final op of the whole test.
module mbist_addr_gen
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int NUM_BG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        elem,
  output logic [1:0]        bg,
  output logic              phase,
  output logic              last
);

  logic [ADDR_W-1:0] idx_q;
  logic [2:0]        elem_q;
  logic [1:0]        bg_q;
  logic              phase_q;
  logic              phase_last, idx_last, elem_last, bg_last;

  always_comb begin
    phase_last = phase_q | ~(ELEM_HAS_R[elem_q] & ELEM_HAS_W[elem_q]);
    idx_last   = &idx_q;
    elem_last  = (elem_q == LAST_ELEM);
    bg_last    = (bg_q == 2'(NUM_BG - 1));
  end

  // Descending elements reuse the up-counter by inverting it.
  assign addr  = ELEM_DOWN[elem_q] ? ~idx_q : idx_q;
  assign elem  = elem_q;
  assign bg    = bg_q;
  assign phase = phase_q;
  assign last  = bg_last & elem_last & idx_last & phase_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      elem_q  <= '0;
      bg_q    <= '0;
      phase_q <= 1'b0;
    end else if (clr) begin
      idx_q   <= '0;
      elem_q  <= '0;
      bg_q    <= '0;
      phase_q <= 1'b0;
    end else if (adv) begin
      if (!phase_last) begin
        phase_q <= 1'b1;
      end else begin
        phase_q <= 1'b0;
        idx_q   <= idx_q + 1'b1;
        if (idx_last) begin
          if (!elem_last) begin
            elem_q <= elem_q + 3'd1;
          end else begin
            elem_q <= '0;
            bg_q   <= bg_last ? 2'd0 : bg_q + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller: run FSM, one-cycle read compare pipeline,
// first-fail capture, saturating fail counter and SRAM port mux.
module march_bist_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int NUM_BG = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              opr,
  input  logic              start,
  input  logic              stop_on_fail,
  input  logic              csin,
  input  logic              rwbarin,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datain,
  output logic              sram_cs,
  output logic              sram_rwbar,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] dataout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  output logic [1:0]        fail_bg,
  output logic [CNT_W-1:0]  fail_count,
  output state_t            dbg_state
);

  // Protocol: start is a one-cycle request accepted only with opr=1 outside
  // RUN; done then holds until the next accepted start.
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] gen_addr;
  logic [2:0]        gen_elem;
  logic [1:0]        gen_bg;
  logic              gen_phase, gen_last;
  logic              accept, issue, is_read, ops_done, mismatch, abort, cmp_end;
  logic              cmp_valid, cmp_last;
  logic [DATA_W-1:0] cmp_exp, bg_data, rd_data, wr_data;
  logic [ADDR_W-1:0] cmp_addr;
  logic [2:0]        cmp_elem;
  logic [1:0]        cmp_bg;

  mbist_addr_gen #(.ADDR_W(ADDR_W), .NUM_BG(NUM_BG)) u_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .adv   (issue),
    .addr  (gen_addr),
    .elem  (gen_elem),
    .bg    (gen_bg),
    .phase (gen_phase),
    .last  (gen_last)
  );

  always_comb begin
    for (int i = 0; i < DATA_W; i++) bg_data[i] = bg_bit(gen_bg, i);
    rd_data = ELEM_RPOL[gen_elem] ? ~bg_data : bg_data;
    wr_data = ELEM_WPOL[gen_elem] ? ~bg_data : bg_data;
    is_read = ELEM_HAS_R[gen_elem] & ~gen_phase;
  end

  // An aborting miscompare also blocks the op presented in its compare cycle.
  assign accept   = opr & start & (state != RUN);
  assign mismatch = (state == RUN) & opr & cmp_valid & (sram_rdata != cmp_exp);
  assign abort    = mismatch & stop_on_fail;
  assign cmp_end  = (state == RUN) & opr & cmp_valid & cmp_last;
  assign issue    = (state == RUN) & opr & ~ops_done & ~abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state == RUN);
    done       = (state == DONE);
    pass       = (state == DONE) & ~fail;
    dbg_state  = state;
    sram_cs    = 1'b0;
    sram_rwbar = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state)
      IDLE, DONE: if (accept) state_nxt = RUN;
      RUN: begin
        if (!opr)                  state_nxt = IDLE;
        else if (abort || cmp_end) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!opr) begin
      sram_cs    = csin;
      sram_rwbar = rwbarin;
      sram_addr  = address;
      sram_wdata = datain;
    end else if (state == RUN) begin
      sram_cs    = issue;
      sram_rwbar = is_read;
      sram_addr  = gen_addr;
      sram_wdata = wr_data;
    end
  end

  assign dataout = sram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done   <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_last   <= 1'b0;
      cmp_exp    <= '0;
      cmp_addr   <= '0;
      cmp_elem   <= '0;
      cmp_bg     <= '0;
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_elem  <= '0;
      fail_bg    <= '0;
    end else if (accept) begin
      ops_done   <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_last   <= 1'b0;
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_elem  <= '0;
      fail_bg    <= '0;
    end else begin
      ops_done  <= ops_done | (issue & gen_last);
      cmp_valid <= issue & is_read;
      cmp_last  <= gen_last;
      cmp_exp   <= rd_data;
      cmp_addr  <= gen_addr;
      cmp_elem  <= gen_elem;
      cmp_bg    <= gen_bg;
      if (mismatch) begin
        fail <= 1'b1;
        if (fail_count != '1) fail_count <= fail_count + 1'b1;
        if (!fail) begin
          fail_addr <= cmp_addr;
          fail_data <= sram_rdata;
          fail_elem <= cmp_elem;
          fail_bg   <= cmp_bg;
        end
      end
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: SRAM model with an injectable stuck-at bit,
// a March C- reference model feeding an op queue, and a decoupled monitor.
module tb_march_bist_ctrl;
  import mbist_pkg::*;

  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int NBG = 2;
  localparam int CW  = 8;
  localparam int N   = 1 << AW;
  localparam int T   = 10 * N * NBG;

  logic          clk = 1'b0;
  logic          rst, opr, start, stop_on_fail, csin, rwbarin;
  logic [AW-1:0] address;
  logic [DW-1:0] datain;
  logic          sram_cs, sram_rwbar;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] dataout;
  logic          busy, done, fail, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [2:0]    fail_elem;
  logic [1:0]    fail_bg;
  logic [CW-1:0] fail_count;
  state_t        dbg_state;

  march_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_BG(NBG), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opr(opr), .start(start), .stop_on_fail(stop_on_fail),
    .csin(csin), .rwbarin(rwbarin), .address(address), .datain(datain),
    .sram_cs(sram_cs), .sram_rwbar(sram_rwbar), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .dataout(dataout),
    .busy(busy), .done(done), .fail(fail), .pass(pass), .fail_addr(fail_addr),
    .fail_data(fail_data), .fail_elem(fail_elem), .fail_bg(fail_bg),
    .fail_count(fail_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- SRAM model with stuck-at fault ----------------
  logic [DW-1:0] mem [N];
  logic          fault_en = 1'b0;
  logic          fault_val = 1'b0;
  int            fault_addr = 0;
  int            fault_bit = 0;

  initial for (int i = 0; i < N; i++) mem[i] = '0;

  function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] d, input int a);
    logic [DW-1:0] r;
    r = d;
    if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_rwbar) sram_rdata <= apply_fault(mem[sram_addr], int'(sram_addr));
      else            mem[sram_addr] <= sram_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  logic [AW+DW:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Expected end-of-run status from the reference model.
  logic exp_fail;
  int   exp_cnt, exp_faddr, exp_fdata, exp_felem, exp_fbg, exp_done_cyc;

  // March C- described directly from the algorithm: per element a direction,
  // optional read polarity and optional write polarity (-1 = none).
  int            el_down [6] = '{0, 0, 0, 1, 1, 0};
  int            el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
  int            el_wr   [6] = '{0, 1, 0, 1, 0, -1};
  logic [DW-1:0] bgtab   [4] = '{8'h00, 8'h55, 8'h33, 8'h0F};

  task automatic model_run(input bit sof);
    logic [DW-1:0] m [N];
    logic [DW-1:0] expv, obs;
    int k, a;
    bit stopped;
    k = 0; stopped = 0;
    exp_fail = 0; exp_cnt = 0; exp_faddr = 0; exp_fdata = 0; exp_felem = 0; exp_fbg = 0;
    exp_done_cyc = T + 2;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int b = 0; b < NBG; b++)
      for (int e = 0; e < 6; e++)
        for (int j = 0; j < N; j++) begin
          a = (el_down[e] != 0) ? N - 1 - j : j;
          if (el_rd[e] >= 0 && !stopped) begin
            expv = (el_rd[e] == 1) ? ~bgtab[b] : bgtab[b];
            exp_q.push_back({1'b1, AW'(a), DW'(0)});
            obs = apply_fault(m[a], a);
            if (obs != expv) begin
              if (!exp_fail) begin
                exp_faddr = a; exp_fdata = int'(obs); exp_felem = e; exp_fbg = b;
              end
              exp_fail = 1;
              if (exp_cnt < (1 << CW) - 1) exp_cnt++;
              if (sof) begin
                stopped = 1;
                exp_done_cyc = k + 3;
              end
            end
            k++;
          end
          if (el_wr[e] >= 0 && !stopped) begin
            m[a] = (el_wr[e] == 1) ? ~bgtab[b] : bgtab[b];
            exp_q.push_back({1'b0, AW'(a), m[a]});
            k++;
          end
        end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [AW+DW:0] act, expo;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && opr && sram_cs) begin
        act = sram_rwbar ? {1'b1, sram_addr, DW'(0)} : {1'b0, sram_addr, sram_wdata};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_op act=%0h exp=none", act);
        end else begin
          expo = exp_q.pop_front();
          check("bist_op", act, expo);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_full(input bit sof);
    int c;
    exp_q.delete();
    model_run(sof);
    stop_on_fail = sof;
    pulse_start();
    check("busy_cycle1", busy, 1);
    check("done_cycle1", done, 0);
    c = 1;
    while (!done && c < T + 40) begin
      @(negedge clk);
      c++;
    end
    check("done_cycle", c, exp_done_cyc);
    check("busy_at_done", busy, 0);
    check("fail", fail, exp_fail);
    check("pass", pass, !exp_fail);
    check("fail_count", fail_count, exp_cnt);
    check("fail_addr", fail_addr, exp_faddr);
    check("fail_data", fail_data, exp_fdata);
    check("fail_elem", fail_elem, exp_felem);
    check("fail_bg", fail_bg, exp_fbg);
    repeat (4) @(negedge clk);
    check("ops_drained", exp_q.size(), 0);
    check("done_hold", done, 1);
  endtask

  task automatic normal_rw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    csin = 1'b1; rwbarin = 1'b0; address = a; datain = d; start = 1'b1;
    #1;
    check("pass_cs", sram_cs, 1);
    check("pass_rwbar", sram_rwbar, 0);
    check("pass_addr", sram_addr, a);
    check("pass_wdata", sram_wdata, d);
    @(negedge clk);
    check("normal_write", mem[a], d);
    check("start_ignored", busy, 0);
    rwbarin = 1'b1; start = 1'b0;
    @(negedge clk);
    csin = 1'b0;
    check("normal_read", dataout, d);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; opr = 1'b1; start = 1'b0; stop_on_fail = 1'b0;
    csin = 1'b0; rwbarin = 1'b1; address = '0; datain = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_pass", pass, 0);
    check("rst_count", fail_count, 0);
    check("rst_faddr", fail_addr, 0);
    check("rst_cs", sram_cs, 0);

    // fault-free, then the stuck-at-1 bit0 at address 5 with and without abort
    run_full(1'b0);
    fault_en = 1'b1; fault_addr = 5; fault_bit = 0; fault_val = 1'b1;
    run_full(1'b0);
    run_full(1'b1);

    repeat (3) begin
      fault_addr = $urandom_range(0, N - 1);
      fault_bit  = $urandom_range(0, DW - 1);
      fault_val  = 1'($urandom_range(0, 1));
      run_full(1'($urandom_range(0, 1)));
    end
    fault_en = 1'b0;

    // normal mode passthrough
    @(negedge clk);
    opr = 1'b0;
    normal_rw(AW'(2), 8'hC3);
    repeat (3) normal_rw(AW'($urandom_range(0, N - 1)), DW'($urandom_range(0, 255)));
    @(negedge clk);
    opr = 1'b1;

    // opr drop during a failing run
    fault_en = 1'b1; fault_addr = 0; fault_bit = 0; fault_val = 1'b1;
    exp_q.delete();
    model_run(1'b0);
    stop_on_fail = 1'b0;
    pulse_start();
    repeat (39) @(negedge clk);
    opr = 1'b0;
    @(negedge clk);
    check("drop_busy", busy, 0);
    check("drop_done", done, 0);
    check("drop_fail_kept", fail, 1);
    check("drop_count_kept", fail_count, 1);
    exp_q.delete();
    opr = 1'b1;
    fault_en = 1'b0;
    run_full(1'b0);

    // asynchronous reset in the middle of a failing run
    fault_en = 1'b1; fault_addr = 5; fault_bit = 0; fault_val = 1'b1;
    exp_q.delete();
    model_run(1'b0);
    pulse_start();
    repeat ($urandom_range(60, 120)) @(negedge clk);
    check("pre_rst_fail", fail, 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_fail", fail, 0);
    check("arst_count", fail_count, 0);
    check("arst_cs", sram_cs, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    fault_en = 1'b0;
    run_full(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/march_bist_ctrl.md
# march_bist_ctrl

Parametrised March C- memory BIST controller with selectable data backgrounds, first-fail capture and a saturating fail counter. It sits between the system/normal-mode port and a single-port synchronous SRAM. It muxes normal traffic through when not testing. It generalises the single-pattern, fixed-width test sequencer to any address/data width and up to four data backgrounds.

## Interface
- ADDR_W, 6, SRAM address width; N = 2^ADDR_W words
- DATA_W, 8, SRAM data width (≥ 2^(NUM_BG-1))
- NUM_BG, 2, number of data backgrounds run per test, 1..4
- CNT_W, 8, fail counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- opr  in  1  1 = BIST mode, 0 = normal mode
- start  in  1  single-cycle test request (BIST mode only)
- stop_on_fail  in  1  abort test at first miscompare
- csin, rwbarin  in  1 each  normal-mode chip select / read-not-write
- address  in  ADDR_W  normal-mode address
- datain  in  DATA_W  normal-mode write data
- sram_cs, sram_rwbar  out  1 each  SRAM controls
- sram_addr  out  ADDR_W;  sram_wdata  out  DATA_W
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after a read is presented
- dataout  out  DATA_W  = sram_rdata, always
- busy, done, fail, pass  out  1 each  status; pass = done & ~fail
- fail_addr  out  ADDR_W;  fail_data  out  DATA_W;  fail_elem  out  3;  fail_bg  out  2  first-fail record
- fail_count  out  CNT_W  saturating miscompare count

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all registers and status outputs 0.
- Background b: b=0 all zeros; b≥1 bit i = 1 iff bit (b-1) of i is 0 (0x55, 0x33, 0x0F for DATA_W=8). "1" data = bitwise complement.
- Per background, elements M0..M5: M0 ⇑ w0; M1 ⇑ r0,w1; M2 ⇑ r1,w0; M3 ⇓ r0,w1; M4 ⇓ r1,w0; M5 ⇑ r0. ⇑ = addr 0..N-1, ⇓ = N-1..0. One op per cycle. 10N ops per background. T = 10·N·NUM_BG ops total.
- IDLE/DONE + opr & start → RUN. Clear fail, fail_count and the fail record. Backgrounds run 0..NUM_BG-1.
- Read ops: expected value pipelined one cycle and compared with sram_rdata. Mismatch → fail=1 (sticky), fail_count+1 (saturates at 2^CNT_W-1). The first mismatch only loads fail_addr/fail_data(observed)/fail_elem/fail_bg.
- stop_on_fail=1 and mismatch → DONE on that compare edge; ops after the failing read are suppressed (cs=0).
- The last compare of the final background completes → DONE. done=1 until the next accepted start; busy=0.
- opr falls during RUN → IDLE immediately. Results so far retained; done stays 0.
- start during RUN is ignored. start with opr=0 is ignored.
- Port mux: opr=0 → sram_* = csin/rwbarin/address/datain, combinational. opr=1 and RUN → BIST drives (cs=1). opr=1 and not RUN → cs=0, rwbar=1, addr=0, wdata=0.

## Timing
- Edge 0 samples start; busy=1 from cycle 1. Op k (0..T-1) is presented in cycle k+1. Its read data is compared at edge k+2.
- done rises after edge T+1: first high in cycle T+2. busy falls in the same cycle.
- stop_on_fail abort: done high in the cycle after the failing compare edge.
- The fail record and fail_count are valid in the cycle after the compare edge that updates them.
- Async rst mid-RUN: all outputs return to reset values immediately; the SRAM contents are undefined.

## Structure
- Package mbist_pkg: state enum (IDLE/RUN/DONE), march element table (direction, op count, read polarity, write polarity per M0..M5), background function bg(b, DATA_W).
- Sub-module mbist_addr_gen: up/down address counter with element/background sequencing. It outputs addr, elem, bg, op phase and last-op. The top holds the FSM, compare pipeline, fail capture and port mux.

## Test plan
- Fault-free, ADDR_W=3, DATA_W=8, NUM_BG=2 (T=160): start → done high at cycle 162, pass=1, fail_count=0.
- Same config, model bit0 stuck-at-1 at addr 5 → fail=1, fail_addr=5, fail_elem=1, fail_bg=0, fail_data=0x01, fail_count=5.
- Same fault, stop_on_fail=1 → done in the cycle after the first failing compare, fail_count=1, no further cs pulses.
- opr=0: csin=1, rwbarin=0, address=0x2A, datain=0xC3 → write observed at SRAM; a following read gives dataout=0xC3. start is ignored.
- opr dropped at cycle 40 of a run → IDLE next cycle, busy=0, done=0. A later start restarts cleanly and clears fail_count.
- rst asserted mid-RUN (asynchronously, between edges) → busy/done/fail/fail_count=0 before the next edge. Release and start → full pass.
